// File: rtl/mem_stream_pkg.sv
// Shared types and constants for the memory stream reader.
package mem_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [31:0] ADDR_STRIDE = 32'd4;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned CSUM_W      = 16;

endpackage

// File: rtl/byte_fifo.sv
// Small byte FIFO: registered storage, head entry read out directly,
// pointer + occupancy count. DEPTH must be a power of two, >= 2.
module byte_fifo
    import mem_stream_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [BYTE_W-1:0] i_data,
    output logic [BYTE_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [AW:0]       o_count
);

    logic [BYTE_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr;
    logic [AW-1:0]     r_rd;
    logic [AW:0]       r_cnt;
    logic              w_push;
    logic              w_pop;

    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_data  = r_mem[r_rd];
    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;

    // Storage, pointers and occupancy; reset flushes and zeroes the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/mem_stream_reader.sv
// Read sequencer for the byte data memory: walks COUNT word-aligned
// locations from a base address and streams the bytes out via a FIFO.
// Optional running checksum of popped bytes: define MEM_STREAM_CHECKSUM_EN.
module mem_stream_reader
    import mem_stream_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       base_addr,
    input  logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic [31:0]       mem_a,
    output logic              mem_we,
    input  logic [BYTE_W-1:0] mem_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_data,
    output logic [CSUM_W-1:0] checksum
);

    localparam int unsigned FAW = $clog2(FIFO_DEPTH);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_addr;
    logic [CNT_W-1:0]   r_rem;
    logic               r_busy;
    logic               r_done;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [FAW:0]       w_fill;
    logic [BYTE_W-1:0]  w_head;

    assign mem_a     = r_addr;
    assign mem_we    = 1'b0;
    assign busy      = r_busy;
    assign done      = r_done;
    assign out_valid = ~w_empty;
    assign out_data  = w_head;
    assign w_pop     = ~w_empty & out_ready;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (mem_rd),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_fill)
    );

    // Next-state and per-cycle control; a full FIFO always stalls the fetch.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (count != '0) ? FETCH : DONE;
                end
            end
            FETCH: begin
                if (!w_full) begin
                    w_push = 1'b1;
                    if (r_rem == CNT_W'(1)) begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (w_empty || ((w_fill == (FAW+1)'(1)) && w_pop)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, address/length counters and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_rem   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == FETCH) || (w_state_nxt == DRAIN);
            r_done  <= (w_state_nxt == DONE);
            if (w_accept) begin
                r_addr <= base_addr;
                r_rem  <= count;
            end else if (w_push) begin
                r_addr <= r_addr + ADDR_STRIDE;
                r_rem  <= r_rem - CNT_W'(1);
            end
        end
    end

`ifdef MEM_STREAM_CHECKSUM_EN
    logic [CSUM_W-1:0] r_csum;

    // Running sum of bytes leaving the stream, cleared per transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_csum <= '0;
        end else if (w_accept) begin
            r_csum <= '0;
        end else if (w_pop) begin
            r_csum <= r_csum + CSUM_W'(w_head);
        end
    end

    assign checksum = r_csum;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_stream_reader.sv
// Self-checking bench for mem_stream_reader with a byte-memory model and
// an expected-byte scoreboard.
`timescale 1ns/1ps
module tb_mem_stream_reader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [10:0] count;
    logic        busy;
    logic        done;
    logic [31:0] mem_a;
    logic        mem_we;
    logic [7:0]  mem_rd;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [15:0] checksum;

    logic [7:0]  tb_mem [1024];
    logic [7:0]  exp_q [$];
    int          n_cmp;
    int          n_err;
    int          n_pops;
    logic [15:0] csum_model;

    mem_stream_reader #(
        .FIFO_DEPTH (4),
        .CNT_W      (11)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .mem_a     (mem_a),
        .mem_we    (mem_we),
        .mem_rd    (mem_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .checksum  (checksum)
    );

    assign mem_rd = tb_mem[mem_a[11:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every accepted byte is compared against the expected queue.
    always @(negedge clk) begin
        n_cmp++;
        if (mem_we !== 1'b0) begin
            n_err++;
            $display("FAIL mem_we: got %b want 0", mem_we);
        end
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_pops++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL extra_pop: got byte %02h want none", out_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                csum_model = csum_model + 16'(e);
                if (out_data !== e) begin
                    n_err++;
                    $display("FAIL stream_byte: got %02h want %02h", out_data, e);
                end
            end
        end
    end

    function automatic logic [15:0] exp_csum();
`ifdef MEM_STREAM_CHECKSUM_EN
        return csum_model;
`else
        return 16'h0000;
`endif
    endfunction

    // Pulse start for one cycle and queue the bytes the transfer should yield.
    task automatic do_start(input logic [31:0] b, input logic [10:0] c);
        logic [31:0] a;
        @(posedge clk); #1;
        exp_q.delete();
        n_pops     = 0;
        csum_model = 16'h0000;
        for (int i = 0; i < int'(c); i++) begin
            a = b + 32'(i) * 32'd4;
            exp_q.push_back(tb_mem[a[11:2]]);
        end
        start     = 1'b1;
        base_addr = b;
        count     = c;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, out_valid} !== 3'b000 || mem_a !== 32'h0 ||
            out_data !== 8'h00 || checksum !== 16'h0) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b done=%b valid=%b a=%h d=%h cs=%h want all 0",
                     busy, done, out_valid, mem_a, out_data, checksum);
        end
    endtask

    task automatic test_basic();
        logic [31:0] exp_a [3];
        logic [7:0]  exp_d [3];
        bit ok;
        exp_a[0] = 32'h0; exp_a[1] = 32'h4; exp_a[2] = 32'h8;
        exp_d[0] = 8'h10; exp_d[1] = 8'h11; exp_d[2] = 8'h12;
        tb_mem[0] = 8'h10; tb_mem[1] = 8'h11; tb_mem[2] = 8'h12;
        out_ready = 1'b1;
        do_start(32'h0, 11'd3);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c <= 3) begin
                n_cmp++;
                if (mem_a !== exp_a[c-1]) begin
                    n_err++;
                    $display("FAIL basic_addr c%0d: got %h want %h", c, mem_a, exp_a[c-1]);
                end
            end
            n_cmp++;
            if (c == 1 ? (out_valid !== 1'b0 || busy !== 1'b1)
                       : (out_valid !== 1'b1 || out_data !== exp_d[c-2] || done !== 1'b0)) begin
                n_err++;
                $display("FAIL basic_stream c%0d: got v=%b d=%h busy=%b done=%b", c, out_valid,
                         out_data, busy, done);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || checksum !== exp_csum()) begin
            n_err++;
            $display("FAIL basic_done: got done=%b busy=%b cs=%h want 1 0 %h", done, busy,
                     checksum, exp_csum());
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || checksum !== exp_csum()) begin
            n_err++;
            $display("FAIL basic_done_pulse: got done=%b cs=%h want 0 %h", done, checksum,
                     exp_csum());
        end
        ok = 1'b1;
    endtask

    task automatic test_backpressure();
        bit ok;
        for (int i = 0; i < 6; i++) tb_mem[16+i] = 8'h20 + 8'(i);
        out_ready = 1'b0;
        do_start(32'h40, 11'd6);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== 8'h20) begin
                    n_err++;
                    $display("FAIL bp_hold c%0d: got v=%b d=%h want 1 20", c, out_valid, out_data);
                end
            end
            if (c >= 5) begin
                n_cmp++;
                if (mem_a !== 32'h50) begin
                    n_err++;
                    $display("FAIL bp_addr c%0d: got %h want 00000050", c, mem_a);
                end
            end
        end
        @(posedge clk); #1 out_ready = 1'b1;
        wait_done(60, ok);
        n_cmp++;
        if (ok !== 1'b1) begin
            n_err++;
            $display("FAIL bp_timeout: got no done want done");
        end
        n_cmp++;
        if (n_pops != 6 || exp_q.size() != 0 || checksum !== exp_csum()) begin
            n_err++;
            $display("FAIL bp_count: got pops=%0d left=%0d cs=%h want 6 0 %h", n_pops,
                     exp_q.size(), checksum, exp_csum());
        end
    endtask

    task automatic test_zero_count();
        out_ready = 1'b1;
        do_start(32'h80, 11'd0);
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || checksum !== 16'h0) begin
            n_err++;
            $display("FAIL zero_done: got done=%b busy=%b v=%b cs=%h want 1 0 0 0", done, busy,
                     out_valid, checksum);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL zero_after: got done=%b busy=%b v=%b want 0 0 0", done, busy, out_valid);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        tb_mem[1023] = 8'hAB;
        tb_mem[0]    = 8'hCD;
        out_ready    = 1'b1;
        do_start(32'hFFFF_FFFC, 11'd2);
        @(negedge clk);
        n_cmp++;
        if (mem_a !== 32'hFFFF_FFFC) begin
            n_err++;
            $display("FAIL wrap_a0: got %h want fffffffc", mem_a);
        end
        @(negedge clk);
        n_cmp++;
        if (mem_a !== 32'h0000_0000) begin
            n_err++;
            $display("FAIL wrap_a1: got %h want 00000000", mem_a);
        end
        wait_done(20, ok);
        n_cmp++;
        if (ok !== 1'b1 || n_pops != 2) begin
            n_err++;
            $display("FAIL wrap_done: got ok=%b pops=%0d want 1 2", ok, n_pops);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen;
        for (int i = 0; i < 8; i++) tb_mem[64+i] = 8'h60 + 8'(i);
        for (int i = 0; i < 3; i++) tb_mem[128+i] = 8'h90 + 8'(i);
        out_ready = 1'b0;
        do_start(32'h100, 11'd8);
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid: got v=%b busy=%b done=%b want 0 0 0", out_valid, busy, done);
        end
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done === 1'b1 || out_valid === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL rst_quiet: got activity=%b want 0", seen);
        end
        out_ready = 1'b1;
        do_start(32'h200, 11'd3);
        @(negedge clk);
        n_cmp++;
        if (mem_a !== 32'h200) begin
            n_err++;
            $display("FAIL rst_restart_a: got %h want 00000200", mem_a);
        end
        wait_done(20, ok);
        n_cmp++;
        if (ok !== 1'b1 || n_pops != 3 || checksum !== exp_csum()) begin
            n_err++;
            $display("FAIL rst_restart: got ok=%b pops=%0d cs=%h want 1 3 %h", ok, n_pops,
                     checksum, exp_csum());
        end
    endtask

    task automatic test_restart_ignored();
        bit ok;
        for (int i = 0; i < 4; i++) tb_mem[192+i] = 8'hC0 + 8'(i);
        out_ready = 1'b1;
        do_start(32'h300, 11'd4);
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = 32'h500;
        count     = 11'd9;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (mem_a !== 32'h308) begin
            n_err++;
            $display("FAIL ignore_addr: got %h want 00000308", mem_a);
        end
        wait_done(20, ok);
        n_cmp++;
        if (ok !== 1'b1 || n_pops != 4 || checksum !== exp_csum()) begin
            n_err++;
            $display("FAIL ignore_count: got ok=%b pops=%0d cs=%h want 1 4 %h", ok, n_pops,
                     checksum, exp_csum());
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_idle: got busy=%b v=%b want 0 0", busy, out_valid);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        n_pops     = 0;
        csum_model = 16'h0000;
        rst        = 1'b1;
        start      = 1'b0;
        base_addr  = 32'h0;
        count      = 11'd0;
        out_ready  = 1'b0;
        for (int i = 0; i < 1024; i++) tb_mem[i] = 8'(i) ^ 8'h5A;
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_count();
        test_wrap();
        test_reset_mid();
        test_restart_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
